muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low.
REQ-003 start  input  1  request new operation; sampled only in IDLE.
REQ-004 op  input  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV; op[1] meaningful only per REQ-025.
REQ-005 rs_data  input  32  multiplicand / dividend.
REQ-006 rt_data  input  32  multiplier / divisor.
REQ-007 mthi, mtlo  input  1 each  write rs_data into HI / LO.
REQ-008 hi, lo  output  32 each  architectural HI/LO registers, directly registered.
REQ-009 stall  output  1  pipeline hold request.
REQ-010 done  output  1  one-cycle completion pulse.

Function
REQ-011 States SHALL be IDLE, MUL, DIV, FIX, DONE; state and iteration counter SHALL be registered.
REQ-012 IDLE, start=1 at edge E0: latch operands, HI=0, LO=multiplier (MUL) or dividend (DIV), 5-bit iter=0; next state MUL if op[0]=0, else DIV.
REQ-013 MUL iteration: 33-bit sum={1'b0,HI}+(LO[0] ? multiplicand : 0); {HI,LO}={sum,LO}>>1 (sum bit 32 enters HI[31]).
REQ-014 DIV iteration: {r,LO'}={HI,LO}<<1; 33-bit diff={1'b0,r}-{1'b0,divisor}; diff[32]=0 -> HI=diff[31:0], LO=LO'|1; else HI=r, LO=LO'.
REQ-015 One iteration per cycle; iter increments each iteration; iteration with iter==31 is last, then next state FIX (signed op with macro) or DONE.
REQ-016 Unsigned latency: final result in hi/lo after E32; done=1 in cycle after E32; IDLE after E33.
REQ-017 done SHALL be 1 only in DONE; DONE SHALL always return to IDLE next edge.
REQ-018 stall SHALL be 1 when (IDLE and start=1) or state is MUL, DIV, FIX; 0 in DONE and otherwise.
REQ-019 start outside IDLE SHALL be ignored; no queuing.
REQ-020 mthi/mtlo SHALL update HI/LO only in IDLE or DONE; ignored in MUL, DIV, FIX.
REQ-021 start and mthi/mtlo in same IDLE cycle: start wins, writes discarded.
REQ-022 Divide by zero SHALL produce no exception: LO=0xFFFFFFFF, HI=dividend (natural REQ-014 result).
REQ-023 Operands SHALL NOT be re-sampled after E0; rs_data/rt_data changes mid-operation have no effect.

Reset
REQ-024 rst=0 at a rising edge: state=IDLE, iter=0, hi=0, lo=0, done=0, stall=0 (start input masked while rst=0); applies mid-operation, abandoning any result.

Configuration
REQ-025 Macro MULDIV_SIGNED_EN: defined -> op[1]=1 selects signed; at E0 operand magnitudes loaded and sign flags stored; FIX state (one cycle, stall=1) applies correction: MULT negates 64-bit {HI,LO} if signs differ; DIV negates LO if signs differ, HI takes dividend sign; signed latency: done in cycle after E33. Undefined -> op[1] ignored, all ops unsigned, FIX unreachable, no sign logic synthesized.

Verification
REQ-026 MULTU rs=3, rt=5 -> hi=0, lo=15, done exactly one cycle, 33 cycles after start sampled.
REQ-027 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-028 DIVU 100/7 -> lo=14, hi=2; DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234.
REQ-029 start pulses and mthi=1 during MUL -> ignored; result unchanged; stall low only in DONE.
REQ-030 rst=0 at iteration 10 of DIVU -> next cycle IDLE, hi=lo=0, stall=0; new MULTU 2x2 then gives lo=4.
REQ-031 With MULDIV_SIGNED_EN: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; MULT -3x4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4, done in cycle after E33.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / divide unit with architectural HI/LO, one shift-add/subtract step per cycle.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV (op[1]) through a sign-fixup state.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t      state, state_nxt, fin_state;
    logic [4:0]  iter, iter_nxt;
    logic [31:0] hi_nxt, lo_nxt;
    logic [31:0] opnd, opnd_nxt;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] mul_sum;
    logic [31:0] div_r, div_l;
    logic [32:0] div_diff;

`ifdef MULDIV_SIGNED_EN
    logic sgn_op, sgn_op_nxt;
    logic div_op, div_op_nxt;
    logic res_neg, res_neg_nxt;
    logic rem_neg, rem_neg_nxt;

    assign rs_mag    = (op[1] && rs_data[31]) ? -rs_data : rs_data;
    assign rt_mag    = (op[1] && rt_data[31]) ? -rt_data : rt_data;
    assign fin_state = sgn_op ? FIX : DONE;
`else
    logic unused_op;

    assign unused_op = op[1];
    assign rs_mag    = rs_data;
    assign rt_mag    = rt_data;
    assign fin_state = DONE;
`endif

    always_comb begin
        mul_sum        = {1'b0, hi} + {1'b0, (lo[0] ? opnd : 32'd0)};
        {div_r, div_l} = {hi, lo} << 1;
        div_diff       = {1'b0, div_r} - {1'b0, opnd};
    end

    always_comb begin
        state_nxt = state;
        iter_nxt  = iter;
        hi_nxt    = hi;
        lo_nxt    = lo;
        opnd_nxt  = opnd;
`ifdef MULDIV_SIGNED_EN
        sgn_op_nxt  = sgn_op;
        div_op_nxt  = div_op;
        res_neg_nxt = res_neg;
        rem_neg_nxt = rem_neg;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    iter_nxt = '0;
                    hi_nxt   = '0;
                    if (!op[0]) begin
                        lo_nxt    = rt_mag;
                        opnd_nxt  = rs_mag;
                        state_nxt = MUL;
                    end else begin
                        lo_nxt    = rs_mag;
                        opnd_nxt  = rt_mag;
                        state_nxt = DIV;
                    end
`ifdef MULDIV_SIGNED_EN
                    sgn_op_nxt  = op[1];
                    div_op_nxt  = op[0];
                    res_neg_nxt = op[1] & (rs_data[31] ^ rt_data[31]);
                    rem_neg_nxt = op[1] & rs_data[31];
`endif
                end else begin
                    if (mthi) hi_nxt = rs_data;
                    if (mtlo) lo_nxt = rs_data;
                end
            end
            MUL: begin
                hi_nxt   = mul_sum[32:1];
                lo_nxt   = {mul_sum[0], lo[31:1]};
                iter_nxt = iter + 5'd1;
                if (iter == 5'd31) state_nxt = fin_state;
            end
            DIV: begin
                if (!div_diff[32]) begin
                    hi_nxt = div_diff[31:0];
                    lo_nxt = {div_l[31:1], 1'b1};
                end else begin
                    hi_nxt = div_r;
                    lo_nxt = div_l;
                end
                iter_nxt = iter + 5'd1;
                if (iter == 5'd31) state_nxt = fin_state;
            end
            FIX: begin
`ifdef MULDIV_SIGNED_EN
                // Quotient follows sign of the product of signs; remainder follows the dividend.
                if (div_op) begin
                    if (res_neg) lo_nxt = -lo;
                    if (rem_neg) hi_nxt = -hi;
                end else if (res_neg) begin
                    {hi_nxt, lo_nxt} = -{hi, lo};
                end
`endif
                state_nxt = DONE;
            end
            DONE: begin
                if (mthi) hi_nxt = rs_data;
                if (mtlo) lo_nxt = rs_data;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            iter  <= '0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
`ifdef MULDIV_SIGNED_EN
            sgn_op  <= 1'b0;
            div_op  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            iter  <= iter_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            opnd  <= opnd_nxt;
`ifdef MULDIV_SIGNED_EN
            sgn_op  <= sgn_op_nxt;
            div_op  <= div_op_nxt;
            res_neg <= res_neg_nxt;
            rem_neg <= rem_neg_nxt;
`endif
        end
    end

    always_comb begin
        done  = (state == DONE);
        stall = ((state == IDLE) && start && rst) ||
                (state == MUL) || (state == DIV) || (state == FIX);
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed and random operations against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, hi, lo;
    logic        stall, done;
    int          checks = 0;
    int          errors = 0;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .hi(hi), .lo(lo), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not terminate");
    end

    function automatic bit is_signed(input logic [1:0] o);
`ifdef MULDIV_SIGNED_EN
        return o[1];
`else
        return 1'b0;
`endif
    endfunction

    // Returns {hi, lo} expected from plain arithmetic on magnitudes and signs.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit          sgn;
        logic [31:0] ma, mb, q, r;
        logic [63:0] p;
        sgn = is_signed(o);
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        if (!o[0]) begin
            p = {32'd0, ma} * {32'd0, mb};
            if (sgn && (a[31] ^ b[31])) p = -p;
            return p;
        end
        if (mb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return {r, q};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, input bit wr, input string tag);
        logic [63:0] e;
        int          n;
        bit          early_low;
        e = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b; mthi = wr; mtlo = wr;
        #1 chk({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rs_data = $urandom; rt_data = $urandom;
        n = 0;
        early_low = 1'b0;
        while (done !== 1'b1 && n < 60) begin
            if (stall !== 1'b1) early_low = 1'b1;
            if (noise) begin
                start   = 1'($urandom_range(0, 1));
                mthi    = 1'($urandom_range(0, 1));
                mtlo    = 1'($urandom_range(0, 1));
                op      = 2'($urandom);
                rs_data = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk({tag, "_latency"}, 32'(n), is_signed(o) ? 32'd33 : 32'd32);
        chk({tag, "_stall_busy"}, {31'd0, early_low}, 32'd0);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_hi"}, hi, e[63:32]);
        chk({tag, "_lo"}, lo, e[31:0]);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_lo_hold"}, lo, e[31:0]);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; rs_data = '0; rt_data = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;

        run_op(2'b00, 32'd3, 32'd5, 1'b0, 1'b0, "multu_3x5");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
        run_op(2'b01, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
        run_op(2'b01, 32'h1234, 32'd0, 1'b0, 1'b0, "divu_by0");
        run_op(2'b00, 32'h89AB_CDEF, 32'h0012_3456, 1'b1, 1'b0, "multu_noise");
        run_op(2'b01, 32'hDEAD_BEEF, 32'd13, 1'b0, 1'b1, "divu_start_wins");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_m7_2");
        run_op(2'b10, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b0, "mult_m3x4");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_minneg");

        // HI/LO moves while idle
        @(negedge clk); mthi = 1'b1; rs_data = 32'hA5A5_0001;
        @(posedge clk); #1; mthi = 1'b0;
        chk("mthi_idle", hi, 32'hA5A5_0001);
        @(negedge clk); mtlo = 1'b1; rs_data = 32'h5A5A_0002;
        @(posedge clk); #1; mtlo = 1'b0;
        chk("mtlo_idle", lo, 32'h5A5A_0002);
        chk("mtlo_keeps_hi", hi, 32'hA5A5_0001);

        // Reset in the middle of a divide abandons it
        @(negedge clk); start = 1'b1; op = 2'b01; rs_data = 32'd1000; rt_data = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        rst = 1'b1; start = 1'b0;
        run_op(2'b00, 32'd2, 32'd2, 1'b0, 1'b0, "multu_after_rst");

        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(2'($urandom), a, b, 1'(i % 2), 1'b0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
